// File: rtl/s_axi_write_bcast_ctrl.sv
// Broadcasts one AXI4-Lite control write from the host port to NUM_SLR per-SLR slaves and
// folds their B responses into a single host response. One write is in flight at a time.
module s_axi_write_bcast_ctrl #(
   parameter int NUM_SLR                     = 3,
   parameter int C_S_AXI_CONTROL_ADDR_WIDTH  = 9,
   parameter int C_S_AXI_CONTROL_DATA_WIDTH  = 32,
   parameter int C_S_AXI_CONTROL_WSTRB_WIDTH = C_S_AXI_CONTROL_DATA_WIDTH/8
) (
   input  logic                                           ap_clk,
   input  logic                                           ap_rst_n,
   input  logic                                           s_axi_control_AWVALID,
   output logic                                           s_axi_control_AWREADY,
   input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]          s_axi_control_AWADDR,
   input  logic                                           s_axi_control_WVALID,
   output logic                                           s_axi_control_WREADY,
   input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]          s_axi_control_WDATA,
   input  logic [C_S_AXI_CONTROL_WSTRB_WIDTH-1:0]         s_axi_control_WSTRB,
   output logic                                           s_axi_control_BVALID,
   input  logic                                           s_axi_control_BREADY,
   output logic [1:0]                                     s_axi_control_BRESP,
   output logic [NUM_SLR-1:0]                             m_awvalid,
   input  logic [NUM_SLR-1:0]                             m_awready,
   output logic [NUM_SLR*C_S_AXI_CONTROL_ADDR_WIDTH-1:0]  m_awaddr,
   output logic [NUM_SLR-1:0]                             m_wvalid,
   input  logic [NUM_SLR-1:0]                             m_wready,
   output logic [NUM_SLR*C_S_AXI_CONTROL_DATA_WIDTH-1:0]  m_wdata,
   output logic [NUM_SLR*C_S_AXI_CONTROL_WSTRB_WIDTH-1:0] m_wstrb,
   input  logic [NUM_SLR-1:0]                             m_bvalid,
   output logic [NUM_SLR-1:0]                             m_bready,
   input  logic [NUM_SLR*2-1:0]                           m_bresp,
   output logic                                           busy
);
   localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;
   localparam int DW = C_S_AXI_CONTROL_DATA_WIDTH;
   localparam int SW = C_S_AXI_CONTROL_WSTRB_WIDTH;

   // Handshakes (host and per-slave): a beat transfers on the rising edge where valid and
   // ready are both high; valids are driven from registers only and never wait on ready.
   typedef enum logic [1:0] {IDLE = 2'd0, FORK = 2'd1, WAIT_B = 2'd2, RESP = 2'd3} state_t;

   state_t             state_q, state_d;
   logic               aw_held_q, aw_held_d;
   logic               w_held_q, w_held_d;
   logic               awready_q, awready_d;
   logic               wready_q, wready_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [DW-1:0]      data_q, data_d;
   logic [SW-1:0]      strb_q, strb_d;
   logic [NUM_SLR-1:0] aw_done_q, aw_done_d;
   logic [NUM_SLR-1:0] w_done_q, w_done_d;
   logic [NUM_SLR-1:0] b_done_q, b_done_d;
   logic [1:0]         bresp_q, bresp_d;

   // EXOKAY folds to OKAY so the numeric max gives DECERR > SLVERR > OKAY.
   function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] r);
      logic [1:0] m;
      m = (r == 2'b01) ? 2'b00 : r;
      return (m > acc) ? m : acc;
   endfunction

   always_comb begin
      state_d   = state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      bresp_d   = bresp_q;
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;

      case (state_q)
         IDLE: begin
            if (s_axi_control_AWVALID && awready_q) begin
               aw_held_d = 1'b1;
               addr_d    = s_axi_control_AWADDR;
            end
            if (s_axi_control_WVALID && wready_q) begin
               w_held_d = 1'b1;
               data_d   = s_axi_control_WDATA;
               strb_d   = s_axi_control_WSTRB;
            end
            if (aw_held_q && w_held_q) state_d = FORK;
         end
         FORK: begin
            m_awvalid = ~aw_done_q;
            m_wvalid  = ~w_done_q;
            m_bready  = w_done_q & ~b_done_q;
         end
         WAIT_B:  m_bready = ~b_done_q;
         default: ;
      endcase

      aw_done_d = aw_done_q | (m_awvalid & m_awready);
      w_done_d  = w_done_q | (m_wvalid & m_wready);
      b_done_d  = b_done_q | (m_bvalid & m_bready);
      for (int i = 0; i < NUM_SLR; i++) begin
         if (m_bvalid[i] && m_bready[i]) bresp_d = merge_resp(bresp_d, m_bresp[2*i +: 2]);
      end

      case (state_q)
         FORK: begin
            if ((&aw_done_d) && (&w_done_d)) state_d = (&b_done_d) ? RESP : WAIT_B;
         end
         WAIT_B: begin
            if (&b_done_d) state_d = RESP;
         end
         RESP: begin
            if (s_axi_control_BREADY) begin
               state_d   = IDLE;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               aw_done_d = '0;
               w_done_d  = '0;
               b_done_d  = '0;
               bresp_d   = 2'b00;
            end
         end
         default: ;
      endcase

      awready_d = (state_d == IDLE) && !aw_held_d;
      wready_d  = (state_d == IDLE) && !w_held_d;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q   <= IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         aw_done_q <= '0;
         w_done_q  <= '0;
         b_done_q  <= '0;
         bresp_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         b_done_q  <= b_done_d;
         bresp_q   <= bresp_d;
      end
   end

   assign s_axi_control_AWREADY = awready_q;
   assign s_axi_control_WREADY  = wready_q;
   assign s_axi_control_BVALID  = (state_q == RESP);
   assign s_axi_control_BRESP   = bresp_q;
   assign m_awaddr              = {NUM_SLR{addr_q}};
   assign m_wdata               = {NUM_SLR{data_q}};
   assign m_wstrb               = {NUM_SLR{strb_q}};
   assign busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_s_axi_write_bcast_ctrl.sv
// Self-checking bench for s_axi_write_bcast_ctrl: host driver task, per-slave responder
// models with configurable ready/B delays, and a response scoreboard.
module tb_s_axi_write_bcast_ctrl;
   localparam int NS = 3;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int SW = 4;

   logic               ap_clk = 1'b0;
   logic               ap_rst_n = 1'b0;
   logic               AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
   logic [AW-1:0]      AWADDR = '0;
   logic [DW-1:0]      WDATA = '0;
   logic [SW-1:0]      WSTRB = '0;
   logic               AWREADY, WREADY, BVALID, busy;
   logic [1:0]         BRESP;
   logic [NS-1:0]      m_awvalid, m_wvalid, m_bready;
   logic [NS-1:0]      m_awready = '0, m_wready = '0, m_bvalid = '0;
   logic [NS*2-1:0]    m_bresp = '0;
   logic [NS*AW-1:0]   m_awaddr;
   logic [NS*DW-1:0]   m_wdata;
   logic [NS*SW-1:0]   m_wstrb;

   int n_vec = 0;
   int n_err = 0;
   logic [1:0] exp_q[$];

   // slave model configuration (written by tests) and observations (written by slave model)
   int         aw_dly[NS], w_dly[NS], b_dly[NS];
   logic [1:0] slv_resp[NS];
   int         aw_cnt[NS], w_cnt[NS], b_cnt[NS];
   logic [AW-1:0] aw_seen[NS];
   logic [DW-1:0] d_seen[NS];
   logic [SW-1:0] s_seen[NS];
   int         aw_age[NS], w_age[NS];
   int         b_wait[NS] = '{default: -1};
   bit         b_clr[NS];
   int         aw_base[NS], w_base[NS], b_base[NS];
   int         b_base_sum;

   s_axi_write_bcast_ctrl dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_axi_control_AWVALID(AWVALID), .s_axi_control_AWREADY(AWREADY),
      .s_axi_control_AWADDR(AWADDR),
      .s_axi_control_WVALID(WVALID), .s_axi_control_WREADY(WREADY),
      .s_axi_control_WDATA(WDATA), .s_axi_control_WSTRB(WSTRB),
      .s_axi_control_BVALID(BVALID), .s_axi_control_BREADY(BREADY),
      .s_axi_control_BRESP(BRESP),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .busy(busy)
   );

   // clock / reset
   always #5 ap_clk = ~ap_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   // Slave responders act on the falling edge; a valid&ready seen here transfers on the
   // next rising edge. B is raised b_dly falling edges after the W transfer.
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         m_awready = '0;
         m_wready  = '0;
         m_bvalid  = '0;
         m_bresp   = '0;
         for (int i = 0; i < NS; i++) begin
            aw_age[i] = 0;
            w_age[i]  = 0;
            b_wait[i] = -1;
            b_clr[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (b_clr[i]) begin
               m_bvalid[i] = 1'b0;
               b_clr[i]    = 1'b0;
            end
            if (b_wait[i] == 0) begin
               m_bvalid[i]      = 1'b1;
               m_bresp[2*i +: 2] = slv_resp[i];
               b_wait[i]        = -1;
            end else if (b_wait[i] > 0) begin
               b_wait[i]--;
            end
            aw_age[i] = m_awvalid[i] ? aw_age[i] + 1 : 0;
            w_age[i]  = m_wvalid[i] ? w_age[i] + 1 : 0;
            m_awready[i] = m_awvalid[i] && (aw_age[i] > aw_dly[i]);
            m_wready[i]  = m_wvalid[i] && (w_age[i] > w_dly[i]);
            if (m_awvalid[i] && m_awready[i]) begin
               aw_cnt[i]++;
               aw_seen[i] = m_awaddr[AW*i +: AW];
            end
            if (m_wvalid[i] && m_wready[i]) begin
               w_cnt[i]++;
               d_seen[i] = m_wdata[DW*i +: DW];
               s_seen[i] = m_wstrb[SW*i +: SW];
               b_wait[i] = b_dly[i];
            end
            if (m_bvalid[i] && m_bready[i]) begin
               b_cnt[i]++;
               b_clr[i] = 1'b1;
            end
         end
      end
   end

   // reference model: any DECERR wins, then any SLVERR, else OKAY (EXOKAY counts as OKAY)
   function automatic logic [1:0] ref_merge();
      bit any_dec = 1'b0;
      bit any_slv = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (slv_resp[i] == 2'b11) any_dec = 1'b1;
         if (slv_resp[i] == 2'b10) any_slv = 1'b1;
      end
      return any_dec ? 2'b11 : (any_slv ? 2'b10 : 2'b00);
   endfunction

   function automatic int b_total();
      int t = 0;
      for (int i = 0; i < NS; i++) t += b_cnt[i];
      return t;
   endfunction

   task automatic snap();
      b_base_sum = 0;
      for (int i = 0; i < NS; i++) begin
         aw_base[i] = aw_cnt[i];
         w_base[i]  = w_cnt[i];
         b_base[i]  = b_cnt[i];
         b_base_sum += b_cnt[i];
      end
   endtask

   task automatic set_slaves(input int awd, input int wd, input int bd, input logic [1:0] r);
      for (int i = 0; i < NS; i++) begin
         aw_dly[i] = awd; w_dly[i] = wd; b_dly[i] = bd; slv_resp[i] = r;
      end
   endtask

   // Host driver: one full write. cyc counts falling edges; cap is the falling edge before
   // the rising edge on which the later of AW/W is captured.
   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input int aw_lag, input int w_lag, input int bready_lag,
                             output logic [1:0] resp, output int cap, output int awv, output int bv,
                             output int bat, output bit hold_ok, output bit tmo);
      int cyc = 0;
      bit aw_ok = 1'b0, w_ok = 1'b0, b_ok = 1'b0;
      logic [1:0] r0 = 2'b00;
      cap = -1; awv = -1; bv = -1; bat = -1; hold_ok = 1'b1; tmo = 1'b0; resp = 2'b00;
      while (!b_ok) begin
         @(negedge ap_clk);
         if (awv < 0 && (|m_awvalid)) awv = cyc;
         if (aw_ok && AWREADY !== 1'b0) hold_ok = 1'b0;
         if (w_ok && WREADY !== 1'b0) hold_ok = 1'b0;
         if (bv >= 0 && (BVALID !== 1'b1 || BRESP !== r0)) hold_ok = 1'b0;
         AWVALID = !aw_ok && (cyc >= aw_lag);
         AWADDR  = a;
         WVALID  = !w_ok && (cyc >= w_lag);
         WDATA   = d;
         WSTRB   = s;
         if (AWVALID && AWREADY === 1'b1) aw_ok = 1'b1;
         if (WVALID && WREADY === 1'b1) w_ok = 1'b1;
         if (aw_ok && w_ok && cap < 0) cap = cyc;
         if (BVALID === 1'b1 && bv < 0) begin
            bv  = cyc;
            r0  = BRESP;
            bat = b_total();
         end
         BREADY = (bv >= 0) && (cyc - bv >= bready_lag);
         if (BVALID === 1'b1 && BREADY) begin
            b_ok = 1'b1;
            resp = BRESP;
         end
         cyc++;
         if (cyc > 500) begin
            tmo = 1'b1;
            break;
         end
      end
      @(negedge ap_clk);
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      BREADY  = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      repeat (3) @(negedge ap_clk);
      n_vec++;
      if ({AWREADY, WREADY, BVALID, busy} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctrl: awready/wready/bvalid/busy=%b, required 0000", {AWREADY, WREADY, BVALID, busy});
      end
      n_vec++;
      if (BRESP !== 2'b00 || m_awvalid !== '0 || m_wvalid !== '0 || m_bready !== '0) begin
         n_err++;
         $display("FAIL reset_master: bresp=%b awv=%b wv=%b bready=%b, required all 0", BRESP, m_awvalid, m_wvalid, m_bready);
      end
      n_vec++;
      if (m_awaddr !== '0 || m_wdata !== '0 || m_wstrb !== '0) begin
         n_err++;
         $display("FAIL reset_payload: addr=%h data=%h strb=%h, required 0", m_awaddr, m_wdata, m_wstrb);
      end
      ap_rst_n = 1'b1;
      #1;
      n_vec++;
      if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_ready: awready=%b wready=%b, required 0 before first edge", AWREADY, WREADY);
      end
      @(negedge ap_clk);
      n_vec++;
      if (AWREADY !== 1'b1 || WREADY !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_first_edge: awready=%b wready=%b busy=%b, required 1 1 0", AWREADY, WREADY, busy);
      end
   endtask

   task automatic test_all_ready();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      logic [AW-1:0] a; logic [DW-1:0] d;
      a = 9'h044; d = $urandom;
      set_slaves(0, 0, 0, 2'b00);
      snap();
      exp_q.push_back(ref_merge());
      host_write(a, d, 4'hF, 0, 0, 0, resp, cap, awv, bv, bat, hok, tmo);
      e = exp_q.pop_front();
      n_vec++;
      if (tmo || resp !== e) begin
         n_err++; $display("FAIL t1_resp: bresp=%b timeout=%0b, required %b", resp, tmo, e);
      end
      n_vec++;
      if (awv - cap !== 2) begin
         n_err++; $display("FAIL t1_mvalid_latency: %0d edges after capture, required 2", awv - cap);
      end
      n_vec++;
      if (bv - cap !== 4) begin
         n_err++; $display("FAIL t1_bvalid_latency: seen %0d falling edges after capture, required 4", bv - cap);
      end
      for (int i = 0; i < NS; i++) begin
         n_vec++;
         if (aw_cnt[i] - aw_base[i] !== 1 || w_cnt[i] - w_base[i] !== 1 || b_cnt[i] - b_base[i] !== 1) begin
            n_err++;
            $display("FAIL t1_beats slave %0d: aw=%0d w=%0d b=%0d, required 1 1 1", i,
                     aw_cnt[i] - aw_base[i], w_cnt[i] - w_base[i], b_cnt[i] - b_base[i]);
         end
         n_vec++;
         if (aw_seen[i] !== a || d_seen[i] !== d || s_seen[i] !== 4'hF) begin
            n_err++;
            $display("FAIL t1_payload slave %0d: addr=%h data=%h strb=%h, required %h %h f", i, aw_seen[i], d_seen[i], s_seen[i], a, d);
         end
      end
   endtask

   task automatic test_slow_slaves();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      set_slaves(0, 0, 0, 2'b00);
      aw_dly[1] = 5;
      w_dly[2]  = 2;
      snap();
      exp_q.push_back(ref_merge());
      host_write(9'h0F0, 32'h1234_5678, 4'h3, 0, 0, 0, resp, cap, awv, bv, bat, hok, tmo);
      e = exp_q.pop_front();
      n_vec++;
      if (tmo || resp !== e) begin
         n_err++; $display("FAIL t2_resp: bresp=%b timeout=%0b, required %b", resp, tmo, e);
      end
      n_vec++;
      if (bat - b_base_sum !== NS) begin
         n_err++; $display("FAIL t2_b_before_host: %0d slave B done at host BVALID, required %0d", bat - b_base_sum, NS);
      end
      for (int i = 0; i < NS; i++) begin
         n_vec++;
         if (aw_cnt[i] - aw_base[i] !== 1 || w_cnt[i] - w_base[i] !== 1 || b_cnt[i] - b_base[i] !== 1) begin
            n_err++;
            $display("FAIL t2_beats slave %0d: aw=%0d w=%0d b=%0d, required 1 1 1", i,
                     aw_cnt[i] - aw_base[i], w_cnt[i] - w_base[i], b_cnt[i] - b_base[i]);
         end
      end
      set_slaves(0, 0, 0, 2'b00);
   endtask

   task automatic test_w_first();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      logic [AW-1:0] a; logic [DW-1:0] d;
      a = 9'h1C8; d = $urandom;
      set_slaves(0, 0, 1, 2'b01);
      snap();
      exp_q.push_back(ref_merge());
      host_write(a, d, 4'hA, 4, 0, 0, resp, cap, awv, bv, bat, hok, tmo);
      e = exp_q.pop_front();
      n_vec++;
      if (tmo || resp !== e) begin
         n_err++; $display("FAIL t3_resp: bresp=%b timeout=%0b, required %b", resp, tmo, e);
      end
      n_vec++;
      if (!hok || cap !== 4) begin
         n_err++; $display("FAIL t3_w_held: hold_ok=%0b capture at %0d, required 1 at 4", hok, cap);
      end
      n_vec++;
      if (BVALID !== 1'b0) begin
         n_err++; $display("FAIL t3_single_b: bvalid=%b after handshake, required 0", BVALID);
      end
      for (int i = 0; i < NS; i++) begin
         n_vec++;
         if (aw_cnt[i] - aw_base[i] !== 1 || aw_seen[i] !== a || d_seen[i] !== d || s_seen[i] !== 4'hA) begin
            n_err++;
            $display("FAIL t3_payload slave %0d: aw=%0d addr=%h data=%h strb=%h, required 1 %h %h a", i,
                     aw_cnt[i] - aw_base[i], aw_seen[i], d_seen[i], s_seen[i], a, d);
         end
      end
   endtask

   task automatic test_bresp_merge();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      logic [5:0] tbl[3];
      logic [1:0] want[3];
      tbl[0] = {2'b11, 2'b10, 2'b00}; want[0] = 2'b11;
      tbl[1] = {2'b00, 2'b00, 2'b01}; want[1] = 2'b00;
      tbl[2] = {2'b00, 2'b10, 2'b00}; want[2] = 2'b10;
      set_slaves(0, 0, 0, 2'b00);
      for (int k = 0; k < 6; k++) begin
         if (k < 3) begin
            for (int i = 0; i < NS; i++) slv_resp[i] = tbl[k][2*i +: 2];
            exp_q.push_back(want[k]);
         end else begin
            for (int i = 0; i < NS; i++) slv_resp[i] = 2'($urandom_range(3, 0));
            exp_q.push_back(ref_merge());
         end
         host_write(9'($urandom_range(511, 0)), $urandom, 4'hF, 0, 0, 0, resp, cap, awv, bv, bat, hok, tmo);
         e = exp_q.pop_front();
         n_vec++;
         if (tmo || resp !== e) begin
            n_err++;
            $display("FAIL t4_merge case %0d (%b %b %b): bresp=%b, required %b", k, slv_resp[0], slv_resp[1], slv_resp[2], resp, e);
         end
      end
   endtask

   task automatic test_bready_hold();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      set_slaves(0, 0, 0, 2'b00);
      slv_resp[2] = 2'b10;
      exp_q.push_back(ref_merge());
      host_write(9'h0AA, 32'h0BAD_F00D, 4'hF, 0, 0, 10, resp, cap, awv, bv, bat, hok, tmo);
      e = exp_q.pop_front();
      n_vec++;
      if (tmo || resp !== e) begin
         n_err++; $display("FAIL t5_resp: bresp=%b timeout=%0b, required %b", resp, tmo, e);
      end
      n_vec++;
      if (!hok) begin
         n_err++; $display("FAIL t5_hold: bvalid/bresp/awready not held while bready low, hold_ok=%0b required 1", hok);
      end
      set_slaves(0, 0, 0, 2'b00);
      snap();
      exp_q.push_back(ref_merge());
      host_write(9'h010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, cap, awv, bv, bat, hok, tmo);
      e = exp_q.pop_front();
      n_vec++;
      if (tmo || resp !== e) begin
         n_err++; $display("FAIL t5_second_resp: bresp=%b timeout=%0b, required %b", resp, tmo, e);
      end
      for (int i = 0; i < NS; i++) begin
         n_vec++;
         if (aw_cnt[i] - aw_base[i] !== 1 || aw_seen[i] !== 9'h010 || d_seen[i] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL t5_second_payload slave %0d: aw=%0d addr=%h data=%h, required 1 010 deadbeef", i,
                     aw_cnt[i] - aw_base[i], aw_seen[i], d_seen[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      bit reached = 1'b0;
      set_slaves(0, 0, 0, 2'b00);
      slv_resp[1] = 2'b10;
      b_dly[0] = 1000;
      @(negedge ap_clk);
      AWVALID = 1'b1; AWADDR = 9'h1A4;
      WVALID  = 1'b1; WDATA = $urandom; WSTRB = 4'hF;
      @(negedge ap_clk);
      AWVALID = 1'b0; WVALID = 1'b0;
      for (int c = 0; c < 50 && !reached; c++) begin
         @(negedge ap_clk);
         if (busy === 1'b1 && m_awvalid === '0 && m_wvalid === '0 && m_bready === 3'b001) reached = 1'b1;
      end
      n_vec++;
      if (!reached) begin
         n_err++; $display("FAIL t6_wait_b: busy=%b bready=%b, required busy 1 with bready 001", busy, m_bready);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      n_vec++;
      if ({AWREADY, WREADY, BVALID, busy} !== 4'b0000 || BRESP !== 2'b00) begin
         n_err++;
         $display("FAIL t6_reset_ctrl: awready/wready/bvalid/busy=%b bresp=%b, required 0000 00", {AWREADY, WREADY, BVALID, busy}, BRESP);
      end
      n_vec++;
      if (m_awvalid !== '0 || m_wvalid !== '0 || m_bready !== '0 || m_awaddr !== '0 || m_wdata !== '0) begin
         n_err++;
         $display("FAIL t6_reset_master: awv=%b wv=%b bready=%b addr=%h, required all 0", m_awvalid, m_wvalid, m_bready, m_awaddr);
      end
      repeat (2) @(negedge ap_clk);
      b_dly[0] = 0;
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      snap();
      exp_q.push_back(ref_merge());
      host_write(9'h033, 32'hCAFE_0001, 4'h5, 0, 0, 0, resp, cap, awv, bv, bat, hok, tmo);
      e = exp_q.pop_front();
      n_vec++;
      if (tmo || resp !== e) begin
         n_err++; $display("FAIL t6_fresh_resp: bresp=%b timeout=%0b, required %b", resp, tmo, e);
      end
      for (int i = 0; i < NS; i++) begin
         n_vec++;
         if (aw_cnt[i] - aw_base[i] !== 1 || b_cnt[i] - b_base[i] !== 1 || aw_seen[i] !== 9'h033 || d_seen[i] !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL t6_fresh_payload slave %0d: aw=%0d b=%0d addr=%h data=%h, required 1 1 033 cafe0001", i,
                     aw_cnt[i] - aw_base[i], b_cnt[i] - b_base[i], aw_seen[i], d_seen[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] resp, e; int cap, awv, bv, bat; bit hok, tmo;
      logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < NS; i++) begin
            aw_dly[i]   = $urandom_range(3, 0);
            w_dly[i]    = $urandom_range(3, 0);
            b_dly[i]    = $urandom_range(3, 0);
            slv_resp[i] = 2'($urandom_range(3, 0));
         end
         a = 9'($urandom_range(511, 0)); d = $urandom; s = 4'($urandom_range(15, 0));
         snap();
         exp_q.push_back(ref_merge());
         host_write(a, d, s, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0),
                    resp, cap, awv, bv, bat, hok, tmo);
         e = exp_q.pop_front();
         n_vec++;
         if (tmo || resp !== e || !hok) begin
            n_err++; $display("FAIL rnd%0d_resp: bresp=%b timeout=%0b hold_ok=%0b, required %b 0 1", k, resp, tmo, hok, e);
         end
         n_vec++;
         if (bat - b_base_sum !== NS) begin
            n_err++; $display("FAIL rnd%0d_b_before_host: %0d slave B done, required %0d", k, bat - b_base_sum, NS);
         end
         for (int i = 0; i < NS; i++) begin
            n_vec++;
            if (aw_cnt[i] - aw_base[i] !== 1 || w_cnt[i] - w_base[i] !== 1 || b_cnt[i] - b_base[i] !== 1 ||
                aw_seen[i] !== a || d_seen[i] !== d || s_seen[i] !== s) begin
               n_err++;
               $display("FAIL rnd%0d_slave %0d: aw=%0d w=%0d b=%0d addr=%h data=%h strb=%h, required 1 1 1 %h %h %h", k, i,
                        aw_cnt[i] - aw_base[i], w_cnt[i] - w_base[i], b_cnt[i] - b_base[i], aw_seen[i], d_seen[i], s_seen[i], a, d, s);
            end
         end
      end
   endtask

   initial begin
      set_slaves(0, 0, 0, 2'b00);
      test_reset();
      test_all_ready();
      test_slow_slaves();
      test_w_first();
      test_bresp_merge();
      test_bready_hold();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
